// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock time-setting controller: FSM states,
// field codes and BCD range limits.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_SEC  = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_HR   = 2'd3;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

endpackage

// File: rtl/clock_set_ctrl_bcd_updown.sv
// Combinational two-digit BCD increment/decrement with wrap between 00
// and a programmable maximum.
module bcd_updown (
    input  logic [7:0] value,
    input  logic [7:0] max_value,
    input  logic       up,
    input  logic       down,
    output logic [7:0] result
);

    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        result = value;
        if (up && !down) begin
            if (value == max_value)
                result = 8'h00;
            else if (value[3:0] == 4'd9)
                result = {value[7:4] + 4'd1, 4'd0};
            else
                result = {value[7:4], value[3:0] + 4'd1};
        end else if (down && !up) begin
            if (value == 8'h00)
                result = max_value;
            else if (value[3:0] == 4'd0)
                result = {value[7:4] - 4'd1, 4'd9};
            else
                result = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven edit session for the BCD wall clock; applies the edit
// buffer field by field on set/set_type with confirm held low.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 60_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic [7:0] set,
    output logic [1:0] set_type,
    output logic       confirm,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic [7:0] edit_hr,
    output logic [7:0] edit_min,
    output logic [7:0] edit_sec,
    output logic       busy
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  btn_prev;
    logic [3:0]                  pulse;

    // Bit order in the button vector: {ok, down, up, mode}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            btn_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage sample the previous stage's old value.
            sync_q[0] <= {btn_ok, btn_down, btn_up, btn_mode};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            btn_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~btn_prev;

    logic mode_p, up_p, down_p, ok_p;
    assign mode_p = pulse[0];
    assign up_p   = pulse[1];
    assign down_p = pulse[2];
    assign ok_p   = pulse[3];

    logic [7:0] hr_next, min_next, sec_next;

    bcd_updown u_hr (
        .value     (edit_hr),
        .max_value (HR_MAX),
        .up        (up_p && field_sel == FLD_HR),
        .down      (down_p && field_sel == FLD_HR),
        .result    (hr_next)
    );

    bcd_updown u_min (
        .value     (edit_min),
        .max_value (MS_MAX),
        .up        (up_p && field_sel == FLD_MIN),
        .down      (down_p && field_sel == FLD_MIN),
        .result    (min_next)
    );

    bcd_updown u_sec (
        .value     (edit_sec),
        .max_value (MS_MAX),
        .up        (up_p && field_sel == FLD_SEC),
        .down      (down_p && field_sel == FLD_SEC),
        .result    (sec_next)
    );

    state_t           state;
    logic [CW-1:0]    hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            set       <= 8'h00;
            set_type  <= FLD_NONE;
            confirm   <= 1'b1;
            editing   <= 1'b0;
            busy      <= 1'b0;
            field_sel <= FLD_HR;
            edit_hr   <= 8'h00;
            edit_min  <= 8'h00;
            edit_sec  <= 8'h00;
            hold_cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (mode_p) begin
                        state     <= ST_EDIT;
                        editing   <= 1'b1;
                        field_sel <= FLD_HR;
                    end
                end
                ST_EDIT: begin
                    if (ok_p) begin
                        state    <= ST_LOAD;
                        editing  <= 1'b0;
                        busy     <= 1'b1;
                        confirm  <= 1'b0;
                        set_type <= FLD_SEC;
                        set      <= edit_sec;
                        hold_cnt <= '0;
                    end else begin
                        edit_hr  <= hr_next;
                        edit_min <= min_next;
                        edit_sec <= sec_next;
                        if (mode_p)
                            field_sel <= (field_sel == FLD_SEC) ? FLD_HR : field_sel - 2'd1;
                    end
                end
                ST_LOAD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        // set_type doubles as the field index, so each step moves straight to the next code.
                        case (set_type)
                            FLD_SEC: begin
                                set_type <= FLD_MIN;
                                set      <= edit_min;
                            end
                            FLD_MIN: begin
                                set_type <= FLD_HR;
                                set      <= edit_hr;
                            end
                            default: begin
                                state    <= ST_IDLE;
                                set_type <= FLD_NONE;
                                set      <= 8'h00;
                                confirm  <= 1'b1;
                                busy     <= 1'b0;
                            end
                        endcase
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
